// File: rtl/memory_stage.sv
`default_nettype none
// memory_stage: MEM pipeline stage with a stalling data-memory handshake and a 16-cycle access timeout.
// Optional build macro MEM_ALIGN_CHECK_EN rejects non-word-aligned accesses with a bus_err pulse.
module memory_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] res,
  input  logic [31:0] write_data_ex,
  input  logic [4:0]  write_register_ex,
  input  logic        zero,
  input  logic [2:0]  m_MEM,
  input  logic [1:0]  wb_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_mem,
  output logic        pc_src,
  output logic        bus_err,
  output logic [1:0]  wb_WB,
  output logic [4:0]  write_register_wb,
  output logic [31:0] read_data_wb,
  output logic [31:0] res_wb
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  // tmo_cnt holds the number of ack-less WAIT cycles already elapsed; the 15th one gives up.
  localparam logic [3:0] TIMEOUT_CNT = 4'd14;

  logic [0:0]  state;
  logic [3:0]  tmo_cnt;
  logic [29:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;

  logic access;
  logic misalign;
  logic in_idle;
  logic issue;
  logic waiting;
  logic done;
  logic timeout;
  logic align_err;

  assign access = m_MEM[1] | m_MEM[0];

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = access & (res[1:0] != 2'b00);
`else
  logic unused_res_low;
  assign unused_res_low = ^res[1:0];
  assign misalign       = 1'b0;
`endif

  assign in_idle   = (state == IDLE);
  assign issue     = rst_n & in_idle & access & ~misalign;
  assign align_err = rst_n & in_idle & misalign;
  assign waiting   = rst_n & ~in_idle;
  assign done      = (issue | waiting) & dmem_ack;
  // An ack arriving in the timeout cycle still completes the access.
  assign timeout   = waiting & ~dmem_ack & (tmo_cnt == TIMEOUT_CNT);

  assign dmem_req  = issue | waiting;
  assign stall_mem = (issue | waiting) & ~dmem_ack & ~timeout;
  assign bus_err   = timeout | align_err;
  assign pc_src    = m_MEM[2] & zero;

  always_comb begin
    dmem_we    = m_MEM[0];
    dmem_addr  = {res[31:2], 2'b00};
    dmem_wdata = write_data_ex;
    if (!in_idle) begin
      dmem_we    = req_we;
      dmem_addr  = {req_addr, 2'b00};
      dmem_wdata = req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      tmo_cnt   <= 4'd0;
      req_addr  <= 30'd0;
      req_we    <= 1'b0;
      req_wdata <= 32'd0;
    end else if (in_idle) begin
      if (issue && !dmem_ack) begin
        state     <= WAIT;
        tmo_cnt   <= 4'd0;
        req_addr  <= res[31:2];
        req_we    <= m_MEM[0];
        req_wdata <= write_data_ex;
      end
    end else if (dmem_ack || timeout) begin
      state <= IDLE;
    end else begin
      tmo_cnt <= tmo_cnt + 4'd1;
    end
  end

  // Stalled, timed-out and rejected cycles hand WB a bubble; everything else advances.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_WB             <= 2'b00;
      write_register_wb <= 5'd0;
      read_data_wb      <= 32'd0;
      res_wb            <= 32'd0;
    end else if (stall_mem || timeout || align_err) begin
      wb_WB <= 2'b00;
    end else begin
      wb_WB             <= wb_MEM;
      write_register_wb <= write_register_ex;
      res_wb            <= res;
      if (done && m_MEM[1]) begin
        read_data_wb <= dmem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// tb_memory_stage: directed scenarios plus randomized instruction streams checked against a transaction-level model.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] res;
  logic [31:0] write_data_ex;
  logic [4:0]  write_register_ex;
  logic        zero;
  logic [2:0]  m_MEM;
  logic [1:0]  wb_MEM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        stall_mem;
  logic        pc_src;
  logic        bus_err;
  logic [1:0]  wb_WB;
  logic [4:0]  write_register_wb;
  logic [31:0] read_data_wb;
  logic [31:0] res_wb;

  int n_cmp = 0;
  int n_err = 0;

  initial forever #5 clk = ~clk;

  memory_stage dut (
    .clk(clk), .rst_n(rst_n), .res(res), .write_data_ex(write_data_ex),
    .write_register_ex(write_register_ex), .zero(zero), .m_MEM(m_MEM), .wb_MEM(wb_MEM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall_mem(stall_mem), .pc_src(pc_src),
    .bus_err(bus_err), .wb_WB(wb_WB), .write_register_wb(write_register_wb),
    .read_data_wb(read_data_wb), .res_wb(res_wb)
  );

  task automatic drive(input logic [2:0] m, input logic [31:0] r, input logic [31:0] wd,
                       input logic [4:0] wr, input logic [1:0] wbm, input logic z,
                       input logic ack, input logic [31:0] rd);
    m_MEM = m; res = r; write_data_ex = wd; write_register_ex = wr;
    wb_MEM = wbm; zero = z; dmem_ack = ack; dmem_rdata = rd;
  endtask

  // Idle ALU instruction with recognisable WB fields.
  task automatic park();
    drive(3'b000, 32'h0000_0900, 32'h0, 5'd9, 2'b01, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(3'b010, 32'h40, 32'h0, 5'd3, 2'b11, 1'b0, 1'b1, 32'hAAAA_5555);
    #1;
    n_cmp++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall_mem); end
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", dmem_req); end
    n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
    @(negedge clk);
    n_cmp++; if (wb_WB !== 2'b00) begin n_err++; $display("FAIL reset_wb_WB: got %b want 00", wb_WB); end
    n_cmp++; if (write_register_wb !== 5'd0) begin n_err++; $display("FAIL reset_wreg: got %0d want 0", write_register_wb); end
    n_cmp++; if (read_data_wb !== 32'd0) begin n_err++; $display("FAIL reset_read_data: got %h want 0", read_data_wb); end
    n_cmp++; if (res_wb !== 32'd0) begin n_err++; $display("FAIL reset_res_wb: got %h want 0", res_wb); end
    rst_n = 1'b1;
    park();
  endtask

  task automatic test_load_zero_wait();
    @(negedge clk);
    drive(3'b010, 32'h10, 32'h0, 5'd7, 2'b11, 1'b0, 1'b1, 32'hDEAD_BEEF);
    #1;
    n_cmp++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL load0_stall: got %b want 0", stall_mem); end
    n_cmp++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL load0_req: got %b want 1", dmem_req); end
    n_cmp++; if (dmem_we !== 1'b0) begin n_err++; $display("FAIL load0_we: got %b want 0", dmem_we); end
    n_cmp++; if (dmem_addr !== 32'h10) begin n_err++; $display("FAIL load0_addr: got %h want 10", dmem_addr); end
    @(negedge clk);
    n_cmp++; if (read_data_wb !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL load0_rdata: got %h want deadbeef", read_data_wb); end
    n_cmp++; if (wb_WB !== 2'b11) begin n_err++; $display("FAIL load0_wb_WB: got %b want 11", wb_WB); end
    n_cmp++; if (write_register_wb !== 5'd7) begin n_err++; $display("FAIL load0_wreg: got %0d want 7", write_register_wb); end
    n_cmp++; if (res_wb !== 32'h10) begin n_err++; $display("FAIL load0_res_wb: got %h want 10", res_wb); end
    park();
  endtask

  task automatic test_store_wait();
    int stalls = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_cmp++; if (wb_WB !== 2'b00) begin n_err++; $display("FAIL store_bubble%0d: got %b want 00", i, wb_WB); end
      end
      drive(3'b001, 32'h20, 32'h1234_5678, 5'd4, 2'b10, 1'b0, (i == 3), $urandom);
      #1;
      stalls += int'(stall_mem);
      n_cmp++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL store_req%0d: got %b want 1", i, dmem_req); end
      n_cmp++; if (dmem_we !== 1'b1) begin n_err++; $display("FAIL store_we%0d: got %b want 1", i, dmem_we); end
      n_cmp++; if (dmem_addr !== 32'h20) begin n_err++; $display("FAIL store_addr%0d: got %h want 20", i, dmem_addr); end
      n_cmp++; if (dmem_wdata !== 32'h1234_5678) begin n_err++; $display("FAIL store_wdata%0d: got %h want 12345678", i, dmem_wdata); end
    end
    n_cmp++; if (stalls != 3) begin n_err++; $display("FAIL store_stall_count: got %0d want 3", stalls); end
    @(negedge clk);
    n_cmp++; if (wb_WB !== 2'b10) begin n_err++; $display("FAIL store_wb_WB: got %b want 10", wb_WB); end
    n_cmp++; if (res_wb !== 32'h20) begin n_err++; $display("FAIL store_res_wb: got %h want 20", res_wb); end
    n_cmp++; if (read_data_wb !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL store_rdata_hold: got %h want deadbeef", read_data_wb); end
    park();
  endtask

  task automatic test_timeout();
    int stalls = 0;
    int early_err = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(3'b010, 32'h44, 32'h0, 5'd5, 2'b11, 1'b0, 1'b0, $urandom);
      #1;
      stalls += int'(stall_mem);
      if (i < 15) early_err += int'(bus_err);
    end
    n_cmp++; if (stalls != 15) begin n_err++; $display("FAIL tmo_stall_count: got %0d want 15", stalls); end
    n_cmp++; if (early_err != 0) begin n_err++; $display("FAIL tmo_early_err: got %0d want 0", early_err); end
    n_cmp++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL tmo_bus_err: got %b want 1", bus_err); end
    n_cmp++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL tmo_stall_end: got %b want 0", stall_mem); end
    @(negedge clk);
    n_cmp++; if (wb_WB !== 2'b00) begin n_err++; $display("FAIL tmo_bubble: got %b want 00", wb_WB); end
    n_cmp++; if (read_data_wb !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL tmo_rdata_hold: got %h want deadbeef", read_data_wb); end
    park();
    #1;
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL tmo_req_drop: got %b want 0", dmem_req); end
    n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL tmo_err_pulse: got %b want 0", bus_err); end
    @(negedge clk);
    drive(3'b010, 32'h88, 32'h0, 5'd6, 2'b11, 1'b0, 1'b1, 32'h0BAD_F00D);
    #1;
    n_cmp++; if (dmem_addr !== 32'h88) begin n_err++; $display("FAIL tmo_idle_addr: got %h want 88", dmem_addr); end
    n_cmp++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL tmo_idle_stall: got %b want 0", stall_mem); end
    @(negedge clk);
    n_cmp++; if (read_data_wb !== 32'h0BAD_F00D) begin n_err++; $display("FAIL tmo_next_rdata: got %h want 0badf00d", read_data_wb); end
    park();
  endtask

  task automatic test_branch();
    @(negedge clk);
    drive(3'b100, 32'h0, 32'h0, 5'd2, 2'b01, 1'b1, 1'b1, 32'h0);
    #1;
    n_cmp++; if (pc_src !== 1'b1) begin n_err++; $display("FAIL br_taken: got %b want 1", pc_src); end
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL br_req: got %b want 0", dmem_req); end
    n_cmp++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL br_stall: got %b want 0", stall_mem); end
    @(negedge clk);
    n_cmp++; if (write_register_wb !== 5'd2) begin n_err++; $display("FAIL br_wreg: got %0d want 2", write_register_wb); end
    zero = 1'b0;
    #1;
    n_cmp++; if (pc_src !== 1'b0) begin n_err++; $display("FAIL br_not_taken: got %b want 0", pc_src); end
    park();
  endtask

  task automatic test_alignment();
    @(negedge clk);
    drive(3'b010, 32'h13, 32'h0, 5'd8, 2'b11, 1'b0, 1'b1, 32'hCAFE_F00D);
    #1;
`ifdef MEM_ALIGN_CHECK_EN
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL align_req: got %b want 0", dmem_req); end
    n_cmp++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL align_err: got %b want 1", bus_err); end
    n_cmp++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL align_stall: got %b want 0", stall_mem); end
    @(negedge clk);
    n_cmp++; if (wb_WB !== 2'b00) begin n_err++; $display("FAIL align_bubble: got %b want 00", wb_WB); end
    n_cmp++; if (read_data_wb !== 32'h0BAD_F00D) begin n_err++; $display("FAIL align_rdata_hold: got %h want 0badf00d", read_data_wb); end
    park();
    #1;
    n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL align_err_pulse: got %b want 0", bus_err); end
`else
    n_cmp++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL align_req: got %b want 1", dmem_req); end
    n_cmp++; if (dmem_addr !== 32'h10) begin n_err++; $display("FAIL align_addr: got %h want 10", dmem_addr); end
    n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL align_err: got %b want 0", bus_err); end
    @(negedge clk);
    n_cmp++; if (wb_WB !== 2'b11) begin n_err++; $display("FAIL align_wb_WB: got %b want 11", wb_WB); end
    n_cmp++; if (read_data_wb !== 32'hCAFE_F00D) begin n_err++; $display("FAIL align_rdata: got %h want cafef00d", read_data_wb); end
    park();
`endif
  endtask

  task automatic test_reset_mid_wait();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(3'b010, 32'h30, 32'h0, 5'd11, 2'b11, 1'b0, 1'b0, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    drive(3'b000, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 32'h0);
    #1;
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL rmw_req_in_rst: got %b want 0", dmem_req); end
    n_cmp++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL rmw_stall_in_rst: got %b want 0", stall_mem); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b000, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b1, 32'h5555_AAAA);
    #1;
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL rmw_req_after: got %b want 0", dmem_req); end
    n_cmp++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL rmw_stall_after: got %b want 0", stall_mem); end
    n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL rmw_bus_err: got %b want 0", bus_err); end
    @(negedge clk);
    n_cmp++; if (wb_WB !== 2'b00) begin n_err++; $display("FAIL rmw_wb_WB: got %b want 00", wb_WB); end
    n_cmp++; if (write_register_wb !== 5'd0) begin n_err++; $display("FAIL rmw_wreg: got %0d want 0", write_register_wb); end
    n_cmp++; if (read_data_wb !== 32'd0) begin n_err++; $display("FAIL rmw_rdata: got %h want 0", read_data_wb); end
    n_cmp++; if (res_wb !== 32'd0) begin n_err++; $display("FAIL rmw_res_wb: got %h want 0", res_wb); end
    park();
  endtask

  // Each instruction: kind 0 ALU, 1 load, 2 store, 3 branch. Access latency >15 means the ack never comes.
  task automatic test_random(input int n);
    logic [2:0] m; logic [31:0] r, wd, rd; logic [4:0] wr; logic [1:0] wbm;
    logic z, ack, acc, exp_stall, exp_err, done, pend;
    logic [1:0] exp_wb; logic [4:0] exp_wreg; logic [31:0] exp_rd, exp_res;
    int kind, lat;
    exp_wb = 2'b01; exp_wreg = 5'd9; exp_res = 32'h0000_0900; exp_rd = 32'd0;
    pend = 1'b0;
    for (int t = 0; t < n; t++) begin
      kind = int'($urandom_range(0, 3));
      m = (kind == 1) ? 3'b010 : (kind == 2) ? 3'b001 : (kind == 3) ? 3'b100 : 3'b000;
      acc = (kind == 1) || (kind == 2);
      r = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
      r[1:0] = 2'b00;
`endif
      wd = $urandom; wr = 5'($urandom); wbm = 2'($urandom); z = 1'($urandom);
      lat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 17)) : int'($urandom_range(0, 5));
      done = 1'b0;
      for (int i = 0; !done && i < 20; i++) begin
        @(negedge clk);
        if (pend) begin
          n_cmp++; if (wb_WB !== exp_wb) begin n_err++; $display("FAIL rnd_wb_WB t%0d: got %b want %b", t, wb_WB, exp_wb); end
          n_cmp++; if (write_register_wb !== exp_wreg) begin n_err++; $display("FAIL rnd_wreg t%0d: got %0d want %0d", t, write_register_wb, exp_wreg); end
          n_cmp++; if (res_wb !== exp_res) begin n_err++; $display("FAIL rnd_res_wb t%0d: got %h want %h", t, res_wb, exp_res); end
          n_cmp++; if (read_data_wb !== exp_rd) begin n_err++; $display("FAIL rnd_rdata t%0d: got %h want %h", t, read_data_wb, exp_rd); end
        end
        ack = acc ? (i == lat) : 1'($urandom);
        rd = $urandom;
        drive(m, r, wd, wr, wbm, z, ack, rd);
        #1;
        exp_stall = acc && (i < lat) && (i < 15);
        exp_err = acc && (lat > 15) && (i == 15);
        n_cmp++; if (stall_mem !== exp_stall) begin n_err++; $display("FAIL rnd_stall t%0d c%0d: got %b want %b", t, i, stall_mem, exp_stall); end
        n_cmp++; if (dmem_req !== acc) begin n_err++; $display("FAIL rnd_req t%0d c%0d: got %b want %b", t, i, dmem_req, acc); end
        n_cmp++; if (bus_err !== exp_err) begin n_err++; $display("FAIL rnd_bus_err t%0d c%0d: got %b want %b", t, i, bus_err, exp_err); end
        n_cmp++; if (pc_src !== (m[2] & z)) begin n_err++; $display("FAIL rnd_pc_src t%0d: got %b want %b", t, pc_src, m[2] & z); end
        if (acc) begin
          n_cmp++; if (dmem_we !== (kind == 2)) begin n_err++; $display("FAIL rnd_we t%0d c%0d: got %b want %b", t, i, dmem_we, kind == 2); end
          n_cmp++; if (dmem_addr !== {r[31:2], 2'b00}) begin n_err++; $display("FAIL rnd_addr t%0d c%0d: got %h want %h", t, i, dmem_addr, {r[31:2], 2'b00}); end
          n_cmp++; if (dmem_wdata !== wd) begin n_err++; $display("FAIL rnd_wdata t%0d c%0d: got %h want %h", t, i, dmem_wdata, wd); end
        end
        if (exp_stall) begin
          exp_wb = 2'b00;
        end else begin
          done = 1'b1;
          if (exp_err) begin
            exp_wb = 2'b00;
          end else begin
            exp_wb = wbm; exp_wreg = wr; exp_res = r;
            if (kind == 1) exp_rd = rd;
          end
        end
        pend = 1'b1;
      end
    end
    @(negedge clk);
    n_cmp++; if (wb_WB !== exp_wb) begin n_err++; $display("FAIL rnd_final_wb_WB: got %b want %b", wb_WB, exp_wb); end
    n_cmp++; if (read_data_wb !== exp_rd) begin n_err++; $display("FAIL rnd_final_rdata: got %h want %h", read_data_wb, exp_rd); end
    park();
  endtask

  initial begin
    rst_n = 1'b0;
    park();
    test_reset();
    test_load_zero_wait();
    test_store_wait();
    test_timeout();
    test_branch();
    test_alignment();
    test_reset_mid_wait();
    test_random(60);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
